// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial transmitter with a valid/ready input handshake.
//
// Frame on Tx (line idles high):
//   START (0), DATA_W payload bits LSB first, optional even-parity bit, STOP (1).
// Every bit is held on Tx for exactly DIV clock cycles.
//
// Build option:
//   SERIAL_TX_PARITY_EN  when defined, an even-parity bit (XOR of the payload)
//                        is sent between the last data bit and STOP. When it
//                        is undefined, the PARITY state and parity register
//                        are not built.
//
// Parameters:
//   DATA_W  payload width in bits (1..32)
//   DIV     clock cycles per serial bit (1..65535)
//
// Ports:
//   Clk    rising-edge clock
//   Rst_n  synchronous active-low reset
//   Data   parallel word, captured when Valid && Ready
//   Valid  Data is offered this cycle
//   Ready  1 while idle; a word offered now is accepted at the next edge
//   Tx     registered serial output
//   Busy   complement of Ready; a frame is in progress
//   Done   one-cycle pulse in the first idle cycle after STOP completes
module serial_tx #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] Data,
  input  logic              Valid,
  output logic              Ready,
  output logic              Tx,
  output logic              Busy,
  output logic              Done
);

  localparam int CNT_W = $clog2(DIV + 1);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity;
`endif

  // Last cycle of the current bit period; every state change happens here.
  assign bit_end    = (bit_cnt == CNT_LAST);
  // Tx is registered, so the next payload bit is taken from the shifted value.
  assign shreg_next = shreg >> 1;
  assign Busy       = ~Ready;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      Tx      <= 1'b1;
      Ready   <= 1'b1;
      Done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Valid && Ready) begin
            shreg   <= Data;
`ifdef SERIAL_TX_PARITY_EN
            parity  <= ^Data;
`endif
            state   <= START;
            Ready   <= 1'b0;
            Tx      <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= DATA;
            Tx      <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
`ifdef SERIAL_TX_PARITY_EN
              state   <= PARITY;
              Tx      <= parity;
`else
              state   <= STOP;
              Tx      <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shreg   <= shreg_next;
              Tx      <= shreg_next[0];
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= STOP;
            Tx      <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= IDLE;
            Ready   <= 1'b1;
            Done    <= 1'b1;
            Tx      <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          bit_idx <= '0;
          Ready   <= 1'b1;
          Tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx: two instances (DIV=4 and DIV=1, DATA_W=8) sharing
// clock and reset. Expected line waveforms come from a frame model that lists
// the bits of a frame and repeats each one DIV times.
module tb_serial_tx;
  localparam int DW   = 8;
  localparam int DIVA = 4;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic [DW-1:0] Data, Data1;
  logic          Valid, Valid1;
  logic          Ready, Tx, Busy, Done;
  logic          Ready1, Tx1, Busy1, Done1;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  serial_tx #(.DATA_W(DW), .DIV(DIVA)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Data(Data), .Valid(Valid),
    .Ready(Ready), .Tx(Tx), .Busy(Busy), .Done(Done));

  serial_tx #(.DATA_W(DW), .DIV(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .Data(Data1), .Valid(Valid1),
    .Ready(Ready1), .Tx(Tx1), .Busy(Busy1), .Done(Done1));

  always #5 Clk = ~Clk;

  // Reference frame: start 0, payload LSB first, optional even parity, stop 1,
  // each bit lasting div cycles.
  function automatic void build_frame(input logic [DW-1:0] d, input int div);
    bit bits[$];
    exp_q.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[k])
      for (int r = 0; r < div; r++) exp_q.push_back(bits[k]);
  endfunction

  task automatic test_reset();
    Rst_n = 1'b0; Valid = 1'b1; Data = 8'h3C; Valid1 = 1'b1; Data1 = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      total++;
      if (Tx !== 1'b1 || Ready !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 ||
          Tx1 !== 1'b1 || Ready1 !== 1'b1 || Done1 !== 1'b0) begin
        bad++;
        $display("FAIL reset cyc%0d tx=%b rdy=%b busy=%b done=%b tx1=%b rdy1=%b done1=%b want 1 1 0 0 1 1 0",
                 i, Tx, Ready, Busy, Done, Tx1, Ready1, Done1);
      end
    end
    Valid1 = 1'b0;
  endtask

  // Reset released and 0xA5 offered together: first edge out of reset accepts.
  task automatic test_basic();
    Rst_n = 1'b1; Data = 8'hA5; Valid = 1'b1;
    build_frame(8'hA5, DIVA);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clk);
      total++;
      if (Tx !== exp_q[i] || Ready !== 1'b0 || Busy !== 1'b1 || Done !== 1'b0) begin
        bad++;
        $display("FAIL basic cyc%0d tx=%b rdy=%b busy=%b done=%b want tx=%b rdy=0 busy=1 done=0",
                 i, Tx, Ready, Busy, Done, exp_q[i]);
      end
      if (i == 0) Valid = 1'b0;
    end
    @(negedge Clk);
    total++;
    if (Done !== 1'b1 || Ready !== 1'b1 || Tx !== 1'b1) begin
      bad++;
      $display("FAIL basic_done done=%b rdy=%b tx=%b want 1 1 1", Done, Ready, Tx);
    end
    @(negedge Clk);
    total++;
    if (Done !== 1'b0 || Ready !== 1'b1 || Tx !== 1'b1) begin
      bad++;
      $display("FAIL basic_after done=%b rdy=%b tx=%b want 0 1 1", Done, Ready, Tx);
    end
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    logic [DW-1:0] words [2] = '{8'hA5, 8'h07};
    bit            pbit  [2] = '{1'b0, 1'b1};
    for (int w = 0; w < 2; w++) begin
      Data = words[w]; Valid = 1'b1;
      build_frame(words[w], DIVA);
      for (int i = 0; i < (DW + 3) * DIVA; i++) begin
        @(negedge Clk);
        if (i == 0) Valid = 1'b0;
        if (i >= (DW + 1) * DIVA && i < (DW + 2) * DIVA) begin
          total++;
          if (Tx !== pbit[w]) begin
            bad++;
            $display("FAIL parity w%0d cyc%0d tx=%b want %b", w, i, Tx, pbit[w]);
          end
        end
      end
      @(negedge Clk);
      total++;
      if (Done !== 1'b1) begin
        bad++;
        $display("FAIL parity_done w%0d done=%b want 1", w, Done);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [DW-1:0] d;
    repeat (4) begin
      d = DW'($urandom);
      Data = d; Valid = 1'b1;
      build_frame(d, DIVA);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge Clk);
        total++;
        if (Tx !== exp_q[i] || Ready !== 1'b0 || Done !== 1'b0) begin
          bad++;
          $display("FAIL random d=%h cyc%0d tx=%b rdy=%b done=%b want tx=%b rdy=0 done=0",
                   d, i, Tx, Ready, Done, exp_q[i]);
        end
        if (i == 0) Valid = 1'b0;
      end
      @(negedge Clk);
      total++;
      if (Done !== 1'b1 || Ready !== 1'b1) begin
        bad++;
        $display("FAIL random_done d=%h done=%b rdy=%b want 1 1", d, Done, Ready);
      end
    end
  endtask

  // Data scrambled and Valid pulsed while busy; the frame must not change and
  // nothing may be accepted.
  task automatic test_ignored();
    logic [DW-1:0] d;
    int n;
    d = DW'($urandom);
    Data = d; Valid = 1'b1;
    build_frame(d, DIVA);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      total++;
      if (Tx !== exp_q[i] || Ready !== 1'b0) begin
        bad++;
        $display("FAIL ignored d=%h cyc%0d tx=%b rdy=%b want tx=%b rdy=0", d, i, Tx, Ready, exp_q[i]);
      end
      Data  = DW'($urandom);
      Valid = (i > 1 && i < n - 3) ? 1'($urandom) : 1'b0;
    end
    @(negedge Clk);
    total++;
    if (Done !== 1'b1) begin
      bad++;
      $display("FAIL ignored_done done=%b want 1", Done);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      total++;
      if (Ready !== 1'b1 || Tx !== 1'b1 || Done !== 1'b0) begin
        bad++;
        $display("FAIL ignored_idle cyc%0d rdy=%b tx=%b done=%b want 1 1 0", i, Ready, Tx, Done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [2] = '{8'h01, 8'h80};
    Data = words[0]; Valid = 1'b1;
    for (int w = 0; w < 2; w++) begin
      build_frame(words[w], DIVA);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge Clk);
        total++;
        if (Tx !== exp_q[i] || Ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b w%0d cyc%0d tx=%b rdy=%b want tx=%b rdy=0", w, i, Tx, Ready, exp_q[i]);
        end
        if (i == 0) begin
          if (w == 0) Data = words[1];
          else Valid = 1'b0;
        end
      end
      @(negedge Clk);
      total++;
      if (Done !== 1'b1 || Ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_done w%0d done=%b rdy=%b want 1 1", w, Done, Ready);
      end
    end
  endtask

  task automatic test_mid_reset();
    Data = 8'h00; Valid = 1'b1;
    build_frame(8'h00, DIVA);
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      total++;
      if (Tx !== exp_q[i]) begin
        bad++;
        $display("FAIL midrst_pre cyc%0d tx=%b want %b", i, Tx, exp_q[i]);
      end
      if (i == 0) Valid = 1'b0;
    end
    Rst_n = 1'b0;
    @(negedge Clk);
    total++;
    if (Tx !== 1'b1 || Ready !== 1'b1 || Done !== 1'b0) begin
      bad++;
      $display("FAIL midrst tx=%b rdy=%b done=%b want 1 1 0", Tx, Ready, Done);
    end
    Rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      total++;
      if (Done !== 1'b0 || Tx !== 1'b1 || Ready !== 1'b1) begin
        bad++;
        $display("FAIL midrst_after cyc%0d done=%b tx=%b rdy=%b want 0 1 1", i, Done, Tx, Ready);
      end
    end
  endtask

  task automatic test_div1();
    Data1 = 8'hFF; Valid1 = 1'b1;
    build_frame(8'hFF, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clk);
      total++;
      if (Tx1 !== exp_q[i] || Ready1 !== 1'b0 || Busy1 !== 1'b1 || Done1 !== 1'b0) begin
        bad++;
        $display("FAIL div1 cyc%0d tx=%b rdy=%b busy=%b done=%b want tx=%b rdy=0 busy=1 done=0",
                 i, Tx1, Ready1, Busy1, Done1, exp_q[i]);
      end
      if (i == 0) Valid1 = 1'b0;
    end
    @(negedge Clk);
    total++;
    if (Done1 !== 1'b1 || Ready1 !== 1'b1 || Tx1 !== 1'b1) begin
      bad++;
      $display("FAIL div1_done done=%b rdy=%b tx=%b want 1 1 1", Done1, Ready1, Tx1);
    end
    @(negedge Clk);
    total++;
    if (Done1 !== 1'b0) begin
      bad++;
      $display("FAIL div1_after done=%b want 0", Done1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_ignored();
    test_back_to_back();
    test_mid_reset();
    test_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
